// File: rtl/fpu_mac_avalon_master_if.sv
// Bundle of the host-side job, operand and result ports plus the Avalon-MM
// master port of fpu_mac_avalon_master. clk/reset stay outside the interface.
interface fpu_mac_avalon_master_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             busy;
    logic             op_valid;
    logic             op_ready;
    logic             op_last;
    logic [31:0]      op_a0;
    logic [31:0]      op_b0;
    logic [31:0]      op_a1;
    logic [31:0]      op_b1;
    logic [2:0]       avm_address;
    logic [63:0]      avm_writedata;
    logic [7:0]       avm_byteenable;
    logic             avm_write;
    logic             avm_read;
    logic [63:0]      avm_readdata;
    logic             avm_waitrequest;
    logic             result_valid;
    logic             result_ready;
    logic [31:0]      result_data;
    logic [CNT_W-1:0] set_count;
    logic             error;

    modport master (
        input  start, op_valid, op_last, op_a0, op_b0, op_a1, op_b1,
        input  avm_readdata, avm_waitrequest, result_ready,
        output busy, op_ready, avm_address, avm_writedata, avm_byteenable,
        output avm_write, avm_read, result_valid, result_data, set_count, error
    );

    modport slave (
        output start, op_valid, op_last, op_a0, op_b0, op_a1, op_b1,
        output avm_readdata, avm_waitrequest, result_ready,
        input  busy, op_ready, avm_address, avm_writedata, avm_byteenable,
        input  avm_write, avm_read, result_valid, result_data, set_count, error
    );
endinterface

// File: rtl/fpu_mac_avalon_master.sv
// Avalon-MM master feeding operand sets into the two-lane FPU MAC slave and
// returning the accumulated result. Optional macro TIMEOUT_EN adds a waitrequest timeout.
module fpu_mac_avalon_master #(
    parameter int DRAIN_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input logic                   clk,
    input logic                   reset,
    fpu_mac_avalon_master_if.master bus
);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CLEAR = 4'd1;
    localparam logic [3:0] S_GET   = 4'd2;
    localparam logic [3:0] S_WA0   = 4'd3;
    localparam logic [3:0] S_WA1   = 4'd4;
    localparam logic [3:0] S_WB0   = 4'd5;
    localparam logic [3:0] S_WB1   = 4'd6;
    localparam logic [3:0] S_DRAIN = 4'd7;
    localparam logic [3:0] S_RD    = 4'd8;
    localparam logic [3:0] S_RESP  = 4'd9;

    if (DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("DRAIN_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    logic [3:0]       state_q, state_d;
    logic [31:0]      a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [2:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        wr, rd, xfer_done;

    logic unused_rdata_hi;
    assign unused_rdata_hi = ^bus.avm_readdata[63:32];

    // Bus request is a pure function of the registered state, so it holds through stalls.
    always_comb begin
        addr  = 3'd0;
        wdata = 64'h0;
        be    = 8'h00;
        wr    = 1'b0;
        rd    = 1'b0;
        case (state_q)
            S_CLEAR: begin wr = 1'b1; addr = 3'd2; wdata = 64'h1;          be = 8'hFF; end
            S_WA0:   begin wr = 1'b1; addr = 3'd0; wdata = {32'h0, a0_q};  be = 8'h0F; end
            S_WA1:   begin wr = 1'b1; addr = 3'd0; wdata = {a1_q, 32'h0};  be = 8'hF0; end
            S_WB0:   begin wr = 1'b1; addr = 3'd1; wdata = {32'h0, b0_q};  be = 8'h0F; end
            S_WB1:   begin wr = 1'b1; addr = 3'd1; wdata = {b1_q, 32'h0};  be = 8'hF0; end
            S_RD:    begin rd = 1'b1; addr = 3'd0;                         be = 8'hFF; end
            default: ;
        endcase
    end

    assign xfer_done = (wr || rd) && !bus.avm_waitrequest;

`ifdef TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        a0_d      = a0_q;
        a1_d      = a1_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        last_d    = last_q;
        set_cnt_d = set_cnt_q;
        drn_d     = drn_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_CLEAR;
                    set_cnt_d = '0;
                end
            end
            S_CLEAR: if (xfer_done) state_d = S_GET;
            S_GET: begin
                if (bus.op_valid) begin
                    a0_d    = bus.op_a0;
                    a1_d    = bus.op_a1;
                    b0_d    = bus.op_b0;
                    b1_d    = bus.op_b1;
                    last_d  = bus.op_last;
                    state_d = S_WA0;
                end
            end
            S_WA0: if (xfer_done) state_d = S_WA1;
            S_WA1: if (xfer_done) state_d = S_WB0;
            S_WB0: if (xfer_done) state_d = S_WB1;
            S_WB1: begin
                if (xfer_done) begin
                    if (set_cnt_q != {CNT_W{1'b1}}) set_cnt_d = set_cnt_q + CNT_W'(1);
                    if (last_q) begin
                        state_d = S_DRAIN;
                        drn_d   = DRN_W'(DRAIN_CYCLES - 1);
                    end else begin
                        state_d = S_GET;
                    end
                end
            end
            S_DRAIN: begin
                if (drn_q == '0) state_d = S_RD;
                else             drn_d   = drn_q - DRN_W'(1);
            end
            S_RD: begin
                if (xfer_done) begin
                    rdata_d  = bus.avm_readdata[31:0];
                    rvalid_d = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.result_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef TIMEOUT_EN
        to_cnt_d = '0;
        err_d    = err_q;
        if (state_q == S_IDLE && bus.start) err_d = 1'b0;
        if ((wr || rd) && bus.avm_waitrequest) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d  = S_RESP;
                rvalid_d = 1'b1;
                rdata_d  = 32'hFFFF_FFFF;
                err_d    = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a0_q      <= 32'h0;
            a1_q      <= 32'h0;
            b0_q      <= 32'h0;
            b1_q      <= 32'h0;
            last_q    <= 1'b0;
            set_cnt_q <= '0;
            drn_q     <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            a0_q      <= a0_d;
            a1_q      <= a1_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            last_q    <= last_d;
            set_cnt_q <= set_cnt_d;
            drn_q     <= drn_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
    assign bus.error = err_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.busy           = (state_q != S_IDLE);
    assign bus.op_ready       = (state_q == S_GET);
    assign bus.avm_address    = addr;
    assign bus.avm_writedata  = wdata;
    assign bus.avm_byteenable = be;
    assign bus.avm_write      = wr;
    assign bus.avm_read       = rd;
    assign bus.result_valid   = rvalid_q;
    assign bus.result_data    = rdata_q;
    assign bus.set_count      = set_cnt_q;
endmodule

// File: tb/tb_fpu_mac_avalon_master.sv
// Self-checking bench for fpu_mac_avalon_master: randomized operand jobs and
// Avalon stalls against a transfer-list reference model. Covers TIMEOUT_EN when defined.
module tb_fpu_mac_avalon_master;
    localparam int D    = 4;
    localparam int TO   = 16;
    localparam int CW   = 3;
    localparam int JOB_BUDGET = 2000;

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [7:0]  be;
        logic [63:0] data;
    } xfer_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpu_mac_avalon_master_if #(.CNT_W(CW)) bif();

    fpu_mac_avalon_master #(
        .DRAIN_CYCLES  (D),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif.master)
    );

    int tests_run = 0;
    int tests_failed = 0;

    xfer_t log_q[$];
    xfer_t exp_q[$];
    int    stab_err = 0;
    int    both_err = 0;
    int    opr_bad = 0;
    int    hold_err = 0;
    int    max_stall = 0;
    bit    stuck_wait = 0;
    bit    stall_wb0 = 0;

    logic [31:0] a0_arr[16], a1_arr[16], b0_arr[16], b1_arr[16];
    logic [63:0] rd_value;
    int          got_k;
    logic [31:0] got_data;
    logic [CW-1:0] got_count;
    logic        got_err, got_busy, valid_after, busy_after;

    // Avalon slave model: random stalls per transfer, logs each completed transfer.
    xfer_t cur, held;
    bit    in_xfer = 0;
    int    stall_left = 0;
    always @(negedge clk) begin
        if (bif.avm_write && bif.avm_read) both_err++;
        if (bif.avm_write || bif.avm_read) begin
            cur = '{bif.avm_write, bif.avm_address, bif.avm_byteenable,
                    bif.avm_write ? bif.avm_writedata : 64'h0};
            if (in_xfer) begin
                if (cur !== held) stab_err++;
            end else begin
                held = cur;
                in_xfer = 1;
                stall_left = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
            end
            if (stuck_wait || (stall_wb0 && bif.avm_address == 3'd1 &&
                               bif.avm_byteenable == 8'h0F && bif.set_count != '0)) begin
                bif.avm_waitrequest = 1'b1;
            end else if (stall_left > 0) begin
                bif.avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                bif.avm_waitrequest = 1'b0;
                in_xfer = 0;
                log_q.push_back(cur);
            end
        end else begin
            bif.avm_waitrequest = 1'b0;
            in_xfer = 0;
        end
    end

    task automatic drive_op(input int idx, input int n);
        if (idx < n) begin
            bif.op_valid = 1'b1;
            bif.op_a0 = a0_arr[idx];
            bif.op_a1 = a1_arr[idx];
            bif.op_b0 = b0_arr[idx];
            bif.op_b1 = b1_arr[idx];
            bif.op_last = (idx == n - 1);
        end else begin
            bif.op_valid = 1'b0;
            bif.op_last = 1'b0;
        end
    endtask

    task automatic run_job(input int n, input int rdy_delay, input bit inject_start, input bit rand_ops);
        int idx;
        bit hs;
        if (rand_ops) begin
            for (int i = 0; i < n; i++) begin
                a0_arr[i] = $urandom; a1_arr[i] = $urandom;
                b0_arr[i] = $urandom; b1_arr[i] = $urandom;
            end
        end
        exp_q.delete();
        log_q.delete();
        stab_err = 0; opr_bad = 0; hold_err = 0;
        exp_q.push_back(xfer_t'{1'b1, 3'd2, 8'hFF, 64'h1});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(xfer_t'{1'b1, 3'd0, 8'h0F, {32'h0, a0_arr[i]}});
            exp_q.push_back(xfer_t'{1'b1, 3'd0, 8'hF0, {a1_arr[i], 32'h0}});
            exp_q.push_back(xfer_t'{1'b1, 3'd1, 8'h0F, {32'h0, b0_arr[i]}});
            exp_q.push_back(xfer_t'{1'b1, 3'd1, 8'hF0, {b1_arr[i], 32'h0}});
        end
        exp_q.push_back(xfer_t'{1'b0, 3'd0, 8'hFF, 64'h0});
        rd_value = {$urandom, $urandom};
        bif.avm_readdata = rd_value;
        idx = 0; hs = 0; got_k = -1;
        @(negedge clk);
        bif.start = 1'b1;
        drive_op(idx, n);
        for (int k = 0; k < JOB_BUDGET; k++) begin
            @(negedge clk);
            if (hs) idx++;
            bif.start = inject_start && (k == 7);
            drive_op(idx, n);
            hs = bif.op_valid && bif.op_ready;
            if (bif.op_ready && (bif.avm_write || bif.avm_read || bif.result_valid)) opr_bad++;
            if (bif.result_valid) begin
                got_k = k;
                break;
            end
        end
        bif.op_valid = 1'b0;
        bif.start = 1'b0;
        got_data = bif.result_data;
        got_count = bif.set_count;
        got_err = bif.error;
        got_busy = bif.busy;
        valid_after = 1'b1;
        busy_after = 1'b1;
        if (got_k >= 0) begin
            for (int j = 0; j < rdy_delay; j++) begin
                @(negedge clk);
                if (bif.result_valid !== 1'b1 || bif.result_data !== got_data || bif.busy !== 1'b1) hold_err++;
            end
            bif.result_ready = 1'b1;
            @(negedge clk);
            bif.result_ready = 1'b0;
            valid_after = bif.result_valid;
            busy_after = bif.busy;
        end
    endtask

    task automatic check_log(input string name);
        tests_run++;
        if (log_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s xfer count: got %0d want %0d", name, log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (log_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL %s xfer[%0d]: got %h want %h", name, i, log_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [3:0] ctl;
        tests_run++;
        ctl = {bif.busy, bif.op_ready, bif.avm_write, bif.avm_read};
        if (ctl !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset ctl: got %b want 0000", ctl);
        end
        tests_run++;
        if (bif.result_valid !== 1'b0 || bif.error !== 1'b0 || bif.set_count !== '0) begin
            tests_failed++;
            $display("FAIL reset status: got rv=%b err=%b cnt=%0d want 0 0 0",
                     bif.result_valid, bif.error, bif.set_count);
        end
        tests_run++;
        if (bif.avm_address !== 3'd0 || bif.avm_writedata !== 64'h0 ||
            bif.avm_byteenable !== 8'h00 || bif.result_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset bus: got a=%0d wd=%h be=%h rd=%h want zeros",
                     bif.avm_address, bif.avm_writedata, bif.avm_byteenable, bif.result_data);
        end
    endtask

    task automatic test_single_set;
        a0_arr[0] = 32'h3F80_0000; b0_arr[0] = 32'h4000_0000;
        a1_arr[0] = 32'h4040_0000; b1_arr[0] = 32'h4080_0000;
        run_job(1, 0, 1'b0, 1'b0);
        check_log("single");
        tests_run++;
        if (got_k !== 2 + 5 + D) begin
            tests_failed++;
            $display("FAIL single latency: got %0d want %0d", got_k, 2 + 5 + D);
        end
        tests_run++;
        if (got_data !== rd_value[31:0]) begin
            tests_failed++;
            $display("FAIL single result: got %h want %h", got_data, rd_value[31:0]);
        end
        tests_run++;
        if (got_count !== CW'(1) || got_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single count/busy: got %0d/%b want 1/1", got_count, got_busy);
        end
        tests_run++;
        if (valid_after !== 1'b0 || busy_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL single handshake: got rv=%b busy=%b want 0 0", valid_after, busy_after);
        end
    endtask

    task automatic test_stalls;
        max_stall = 5;
        run_job(3, 0, 1'b0, 1'b1);
        max_stall = 0;
        check_log("stalls");
        tests_run++;
        if (stab_err !== 0) begin
            tests_failed++;
            $display("FAIL stalls stability: got %0d changes want 0", stab_err);
        end
        tests_run++;
        if (got_data !== rd_value[31:0] || got_count !== CW'(3)) begin
            tests_failed++;
            $display("FAIL stalls result: got %h/%0d want %h/3", got_data, got_count, rd_value[31:0]);
        end
    endtask

    task automatic test_hold_ready;
        run_job(3, 10, 1'b0, 1'b1);
        check_log("hold");
        tests_run++;
        if (hold_err !== 0 || got_count !== CW'(3)) begin
            tests_failed++;
            $display("FAIL hold result: got holderr=%0d cnt=%0d want 0 3", hold_err, got_count);
        end
        tests_run++;
        if (valid_after !== 1'b0 || busy_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold release: got rv=%b busy=%b want 0 0", valid_after, busy_after);
        end
    endtask

    task automatic test_busy_start;
        run_job(2, 0, 1'b1, 1'b1);
        check_log("busy_start");
        tests_run++;
        if (opr_bad !== 0) begin
            tests_failed++;
            $display("FAIL busy_start op_ready: got %0d bad cycles want 0", opr_bad);
        end
        tests_run++;
        if (got_k !== 2 + 10 + D) begin
            tests_failed++;
            $display("FAIL busy_start latency: got %0d want %0d", got_k, 2 + 10 + D);
        end
    endtask

    task automatic test_saturate;
        int n;
        n = 9;
        run_job(n, 0, 1'b0, 1'b1);
        check_log("saturate");
        tests_run++;
        if (got_count !== CW'((n > (1 << CW) - 1) ? (1 << CW) - 1 : n)) begin
            tests_failed++;
            $display("FAIL saturate count: got %0d want %0d", got_count, (1 << CW) - 1);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        bit found;
        seen = 0; found = 0;
        stall_wb0 = 1;
        @(negedge clk);
        bif.start = 1'b1;
        bif.op_valid = 1'b1;
        bif.op_last = 1'b0;
        bif.op_a0 = $urandom; bif.op_a1 = $urandom; bif.op_b0 = $urandom; bif.op_b1 = $urandom;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            bif.start = 1'b0;
            if (bif.avm_write && bif.avm_address == 3'd1 && bif.avm_byteenable == 8'h0F &&
                bif.set_count == CW'(1)) seen++;
            if (seen == 3) begin
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL reset_mid stall: got seen=%0d want 3", seen);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bif.avm_write !== 1'b0 || bif.busy !== 1'b0 || bif.avm_address !== 3'd0 ||
            bif.avm_byteenable !== 8'h00 || bif.avm_writedata !== 64'h0 || bif.set_count !== '0 ||
            bif.op_ready !== 1'b0 || bif.result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid outputs: got wr=%b busy=%b a=%0d be=%h cnt=%0d want all 0",
                     bif.avm_write, bif.busy, bif.avm_address, bif.avm_byteenable, bif.set_count);
        end
        reset = 1'b0;
        stall_wb0 = 0;
        bif.op_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef TIMEOUT_EN
    task automatic test_timeout;
        int k_hit;
        k_hit = -1;
        stuck_wait = 1;
        @(negedge clk);
        bif.start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            bif.start = 1'b0;
            if (bif.result_valid) begin
                k_hit = k;
                break;
            end
        end
        tests_run++;
        if (k_hit !== TO) begin
            tests_failed++;
            $display("FAIL timeout latency: got %0d want %0d", k_hit, TO);
        end
        tests_run++;
        if (bif.result_data !== 32'hFFFF_FFFF || bif.error !== 1'b1 || bif.avm_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout result: got %h err=%b wr=%b want ffffffff 1 0",
                     bif.result_data, bif.error, bif.avm_write);
        end
        bif.result_ready = 1'b1;
        @(negedge clk);
        bif.result_ready = 1'b0;
        stuck_wait = 0;
        @(negedge clk);
        tests_run++;
        if (bif.error !== 1'b1 || bif.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout sticky: got err=%b busy=%b want 1 0", bif.error, bif.busy);
        end
        run_job(1, 0, 1'b0, 1'b1);
        tests_run++;
        if (got_err !== 1'b0 || got_data !== rd_value[31:0]) begin
            tests_failed++;
            $display("FAIL timeout restart: got err=%b data=%h want 0 %h", got_err, got_data, rd_value[31:0]);
        end
    endtask
`endif

    task automatic test_bus_rules;
        tests_run++;
        if (both_err !== 0) begin
            tests_failed++;
            $display("FAIL bus write&read: got %0d cycles want 0", both_err);
        end
    endtask

    initial begin
        reset = 1'b1;
        bif.start = 1'b0;
        bif.op_valid = 1'b0;
        bif.op_last = 1'b0;
        bif.op_a0 = '0; bif.op_a1 = '0; bif.op_b0 = '0; bif.op_b1 = '0;
        bif.avm_readdata = '0;
        bif.result_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        reset = 1'b0;
        @(negedge clk);
        test_single_set;
        test_stalls;
        test_hold_ready;
        test_busy_start;
        test_saturate;
        test_reset_mid;
`ifdef TIMEOUT_EN
        test_timeout;
`endif
        test_bus_rules;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
